mips_run_monitor: RTL and testbench

- Synthesizable run-control and termination monitor for the MIPS core, replacing ad-hoc consecutive-NOP counting in benches.
- Observes the fetched instruction stream and ALU result each cycle, and detects end-of-program as a configurable run of consecutive NOPs followed by a drain period.
- Enforces a watchdog cycle limit and exposes cycle, instruction and NOP-run counters.
- Sits beside the core (`main`); used by benches and by FPGA self-test wrappers.

---
 rtl/mips_run_monitor_if.sv | 28 ++
 rtl/mips_run_monitor.sv | 129 ++++++++++++
 tb/tb_mips_run_monitor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_run_monitor_if.sv
// Run-monitor bus: core-side observation inputs plus monitor status/counters.
// master = bench or self-test wrapper, slave = mips_run_monitor.
interface mips_run_monitor_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] alu_result;
  logic              running;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;
  logic [7:0]        nop_run;
  logic [DATA_W-1:0] signature;

  modport master (
    output start, instr_valid, instr, alu_result,
    input  running, done, timeout, cycle_count, instr_count, nop_run, signature
  );

  modport slave (
    input  start, instr_valid, instr, alu_result,
    output running, done, timeout, cycle_count, instr_count, nop_run, signature
  );
endinterface

// File: rtl/mips_run_monitor.sv
// Run-control / termination monitor: end-of-program on a run of NOPs plus drain,
// watchdog on RUN cycles. Optional result signature via MIPS_RUN_MON_SIGNATURE_EN.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | counting cycles, instructions and consecutive NOPs; watchdog armed
// DRAIN   | NOP limit reached, waiting DRAIN_CYCLES before done
// DONE    | program terminated normally, counters frozen
// TIMEOUT | watchdog expired, counters frozen
module mips_run_monitor #(
  parameter int                DATA_W       = 32,
  parameter int                CNT_W        = 16,
  parameter int                NOP_LIMIT    = 4,
  parameter int                DRAIN_CYCLES = 1,
  parameter int                MAX_CYCLES   = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD     = '0
) (
  input  logic             clk,
  input  logic             reset,
  mips_run_monitor_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, TIMEOUT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc_q, cyc_nxt;
  logic [CNT_W-1:0] ic_q, ic_nxt;
  logic [7:0]       nop_q, nop_nxt;
  logic [7:0]       drain_q, drain_nxt;
  logic             running_q, done_q, timeout_q;
  logic             is_nop;
  logic             restart;

  assign is_nop  = (bus.instr == NOP_WORD);
  assign restart = bus.start && (state == IDLE || state == DONE || state == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc_q     <= '0;
      ic_q      <= '0;
      nop_q     <= '0;
      drain_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc_q     <= cyc_nxt;
      ic_q      <= ic_nxt;
      nop_q     <= nop_nxt;
      drain_q   <= drain_nxt;
      running_q <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done_q    <= (state_nxt == DONE);
      timeout_q <= (state_nxt == TIMEOUT);
    end
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_q;
    ic_nxt    = ic_q;
    nop_nxt   = nop_q;
    drain_nxt = drain_q;
    case (state)
      IDLE, DONE, TIMEOUT: begin
        if (bus.start) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
          ic_nxt    = '0;
          nop_nxt   = '0;
        end
      end
      RUN: begin
        cyc_nxt = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        if (bus.instr_valid) begin
          if (is_nop) begin
            nop_nxt = nop_q + 8'd1;
          end else begin
            nop_nxt = '0;
            ic_nxt  = (ic_q == '1) ? ic_q : ic_q + CNT_W'(1);
          end
        end
        // NOP limit takes priority over a watchdog expiring on the same edge
        if (nop_nxt == 8'(NOP_LIMIT)) begin
          drain_nxt = 8'(DRAIN_CYCLES);
          state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else if (cyc_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_nxt = TIMEOUT;
        end
      end
      DRAIN: begin
        cyc_nxt   = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        drain_nxt = drain_q - 8'd1;
        if (drain_q <= 8'd1) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MIPS_RUN_MON_SIGNATURE_EN
  logic [DATA_W-1:0] sig_q, sig_nxt;

  always_comb begin
    sig_nxt = sig_q;
    if (restart)
      sig_nxt = '0;
    else if (state == RUN && bus.instr_valid && !is_nop)
      sig_nxt = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ bus.alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_nxt;
  end

  assign bus.signature = sig_q;
`else
  logic unused_alu;
  assign unused_alu    = ^{bus.alu_result, restart};
  assign bus.signature = '0;
`endif

  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cyc_q;
  assign bus.instr_count = ic_q;
  assign bus.nop_run     = nop_q;
endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: default, DRAIN_CYCLES=0 and MAX_CYCLES=16 instances
// share one stimulus stream; table vectors feed a scoreboard queue.
module tb_mips_run_monitor;
  localparam logic [31:0] NOPW = 32'h0000_0000;
  localparam logic [31:0] INS  = 32'h2273_6000;

  logic clk = 1'b0;
  logic reset;
  logic tb_start, tb_valid;
  logic [31:0] tb_instr, tb_alu;

  always #5 clk = ~clk;

  mips_run_monitor_if #(.DATA_W(32), .CNT_W(16)) if_a ();
  mips_run_monitor_if #(.DATA_W(32), .CNT_W(16)) if_z ();
  mips_run_monitor_if #(.DATA_W(32), .CNT_W(16)) if_w ();

  assign if_a.start = tb_start; assign if_a.instr_valid = tb_valid;
  assign if_a.instr = tb_instr; assign if_a.alu_result  = tb_alu;
  assign if_z.start = tb_start; assign if_z.instr_valid = tb_valid;
  assign if_z.instr = tb_instr; assign if_z.alu_result  = tb_alu;
  assign if_w.start = tb_start; assign if_w.instr_valid = tb_valid;
  assign if_w.instr = tb_instr; assign if_w.alu_result  = tb_alu;

  mips_run_monitor dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  mips_run_monitor #(.DRAIN_CYCLES(0)) dut_z (.clk(clk), .reset(reset), .bus(if_z.slave));
  mips_run_monitor #(.MAX_CYCLES(16))  dut_w (.clk(clk), .reset(reset), .bus(if_w.slave));

  typedef struct {
    logic rst, start, valid;
    logic [31:0] instr, alu;
    logic run, done, to;
    logic [15:0] cyc, ic;
    logic [7:0] nop;
    logic [31:0] sig;
    logic zdone;
  } vec_t;

  typedef struct {
    logic run, done, to;
    logic [15:0] cyc, ic;
    logic [7:0] nop;
    logic [31:0] sig;
    logic zdone;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic add(input logic rst, input logic st, input logic val, input logic [31:0] ins,
                     input logic [31:0] alu, input logic run, input logic dn, input logic to,
                     input int cyc, input int ic, input int nop, input logic [31:0] sig,
                     input logic zd);
    vec_t v;
    v.rst = rst; v.start = st; v.valid = val; v.instr = ins; v.alu = alu;
    v.run = run; v.done = dn; v.to = to; v.cyc = 16'(cyc); v.ic = 16'(ic);
    v.nop = 8'(nop); v.sig = sig; v.zdone = zd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic val,
                      input logic [31:0] ins, input logic [31:0] alu);
    @(negedge clk);
    reset = rst; tb_start = st; tb_valid = val; tb_instr = ins; tb_alu = alu;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sig_exp(input logic [31:0] s);
`ifdef MIPS_RUN_MON_SIGNATURE_EN
    return s;
`else
    return (s & 32'h0);
`endif
  endfunction

  initial begin
    exp_t e;
    reset = 1'b1; tb_start = 1'b0; tb_valid = 1'b0; tb_instr = '0; tb_alu = '0;

    // rst st val instr alu   | run done to cyc ic nop sig zdone
    // defaults: 3 non-NOPs (alu 10,11,21) + 4 NOPs, drain 1
    add(1,0,0,INS ,0  , 0,0,0, 0,0,0, 0 ,0);
    add(1,0,0,INS ,0  , 0,0,0, 0,0,0, 0 ,0);
    add(0,1,0,INS ,0  , 1,0,0, 0,0,0, 0 ,0);
    add(0,0,1,INS ,10 , 1,0,0, 1,1,0, 10,0);
    add(0,0,1,INS ,11 , 1,0,0, 2,2,0, 31,0);
    add(0,0,1,INS ,21 , 1,0,0, 3,3,0, 43,0);
    add(0,0,1,NOPW,77 , 1,0,0, 4,3,1, 43,0);
    add(0,0,1,NOPW,77 , 1,0,0, 5,3,2, 43,0);
    add(0,0,1,NOPW,77 , 1,0,0, 6,3,3, 43,0);
    add(0,0,1,NOPW,77 , 1,0,0, 7,3,4, 43,1);
    add(0,0,0,INS ,0  , 0,1,0, 8,3,4, 43,1);
    add(0,0,0,INS ,0  , 0,1,0, 8,3,4, 43,1);
    // restart from DONE; NOP run broken by a non-NOP
    add(0,1,0,INS ,0  , 1,0,0, 0,0,0, 0 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 1,0,1, 0 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 2,0,2, 0 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 3,0,3, 0 ,0);
    add(0,0,1,INS ,5  , 1,0,0, 4,1,0, 5 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 5,1,1, 5 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 6,1,2, 5 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 7,1,3, 5 ,0);
    add(0,0,1,NOPW,9  , 1,0,0, 8,1,4, 5 ,1);
    add(0,0,0,INS ,0  , 0,1,0, 9,1,4, 5 ,1);
    // instr_valid gaps; DRAIN ignores instr and start
    add(1,0,0,INS ,0  , 0,0,0, 0,0,0, 0 ,0);
    add(0,1,0,INS ,0  , 1,0,0, 0,0,0, 0 ,0);
    add(0,0,1,NOPW,3  , 1,0,0, 1,0,1, 0 ,0);
    add(0,0,0,INS ,99 , 1,0,0, 2,0,1, 0 ,0);
    add(0,0,1,NOPW,3  , 1,0,0, 3,0,2, 0 ,0);
    add(0,0,0,INS ,99 , 1,0,0, 4,0,2, 0 ,0);
    add(0,0,1,NOPW,3  , 1,0,0, 5,0,3, 0 ,0);
    add(0,0,0,INS ,99 , 1,0,0, 6,0,3, 0 ,0);
    add(0,0,1,NOPW,3  , 1,0,0, 7,0,4, 0 ,1);
    add(0,1,1,INS ,99 , 0,1,0, 8,0,4, 0 ,0);
    // reset mid-run with instr_count=5; start ignored in RUN and under reset
    add(0,1,0,INS ,0  , 1,0,0, 0,0,0, 0 ,0);
    add(0,0,1,INS ,1  , 1,0,0, 1,1,0, 1 ,0);
    add(0,1,1,INS ,1  , 1,0,0, 2,2,0, 3 ,0);
    add(0,0,1,INS ,1  , 1,0,0, 3,3,0, 7 ,0);
    add(0,0,1,INS ,1  , 1,0,0, 4,4,0, 15,0);
    add(0,0,1,INS ,1  , 1,0,0, 5,5,0, 31,0);
    add(1,1,1,INS ,1  , 0,0,0, 0,0,0, 0 ,0);
    add(0,0,1,INS ,1  , 0,0,0, 0,0,0, 0 ,0);
    add(0,1,0,INS ,0  , 1,0,0, 0,0,0, 0 ,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; tb_start = vecs[i].start; tb_valid = vecs[i].valid;
      tb_instr = vecs[i].instr; tb_alu = vecs[i].alu;
      e.run = vecs[i].run; e.done = vecs[i].done; e.to = vecs[i].to;
      e.cyc = vecs[i].cyc; e.ic = vecs[i].ic; e.nop = vecs[i].nop;
      e.sig = sig_exp(vecs[i].sig); e.zdone = vecs[i].zdone;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d running", i), 32'(if_a.running), 32'(e.run));
      chk($sformatf("v%0d done", i), 32'(if_a.done), 32'(e.done));
      chk($sformatf("v%0d timeout", i), 32'(if_a.timeout), 32'(e.to));
      chk($sformatf("v%0d cycle_count", i), 32'(if_a.cycle_count), 32'(e.cyc));
      chk($sformatf("v%0d instr_count", i), 32'(if_a.instr_count), 32'(e.ic));
      chk($sformatf("v%0d nop_run", i), 32'(if_a.nop_run), 32'(e.nop));
      chk($sformatf("v%0d signature", i), if_a.signature, e.sig);
      chk($sformatf("v%0d drain0_done", i), 32'(if_z.done), 32'(e.zdone));
    end

    // watchdog: MAX_CYCLES=16 with only non-NOPs
    step(1, 0, 0, INS, 0);
    step(1, 0, 0, INS, 0);
    step(0, 1, 0, INS, 0);
    chk("wd start cyc", 32'(if_w.cycle_count), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 1, INS, 32'(k));
      chk($sformatf("wd cyc k=%0d", k), 32'(if_w.cycle_count), 32'(k));
      chk($sformatf("wd timeout k=%0d", k), 32'(if_w.timeout), 32'(k == 16));
      chk($sformatf("wd done k=%0d", k), 32'(if_w.done), 32'd0);
    end
    chk("wd running", 32'(if_w.running), 32'd0);
    chk("wd instr_count", 32'(if_w.instr_count), 32'd16);
    step(0, 0, 1, INS, 0);
    step(0, 0, 1, NOPW, 0);
    chk("wd frozen cyc", 32'(if_w.cycle_count), 32'd16);
    chk("wd frozen nop", 32'(if_w.nop_run), 32'd0);
    chk("wd frozen timeout", 32'(if_w.timeout), 32'd1);
    step(0, 1, 0, INS, 0);
    chk("wd restart cyc", 32'(if_w.cycle_count), 32'd0);
    chk("wd restart timeout", 32'(if_w.timeout), 32'd0);
    chk("wd restart running", 32'(if_w.running), 32'd1);

    // 4th NOP lands on the watchdog edge: NOP limit wins
    step(1, 0, 0, INS, 0);
    step(0, 1, 0, INS, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, INS, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, NOPW, 0);
    chk("tie pre cyc", 32'(if_w.cycle_count), 32'd15);
    step(0, 0, 1, NOPW, 0);
    chk("tie timeout", 32'(if_w.timeout), 32'd0);
    chk("tie running", 32'(if_w.running), 32'd1);
    chk("tie cyc", 32'(if_w.cycle_count), 32'd16);
    step(0, 0, 0, INS, 0);
    chk("tie done", 32'(if_w.done), 32'd1);
    chk("tie timeout2", 32'(if_w.timeout), 32'd0);
    chk("tie cyc2", 32'(if_w.cycle_count), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
